// File: rtl/bf_pkg.sv
// Shared definitions for the beamformer weight controller.
//   NUM_CH, W_W          : default channel count and weight word width
//   WSEL_*               : wr_sel / rd_sel encodings of the four weight kinds
//   state_t              : controller FSM states
package bf_pkg;

  localparam int unsigned NUM_CH = 8;
  localparam int unsigned W_W    = 5;

  localparam logic [1:0] WSEL_COS1 = 2'd0;
  localparam logic [1:0] WSEL_SIN1 = 2'd1;
  localparam logic [1:0] WSEL_COS2 = 2'd2;
  localparam logic [1:0] WSEL_SIN2 = 2'd3;

  typedef enum logic {
    IDLE  = 1'b0,
    ARMED = 1'b1
  } state_t;

endpackage

// File: rtl/bf_weight_bank.sv
// NUM_CH x 4 x W_W weight register file.
//   clock, reset         : system clock, synchronous active-high reset (clears all words)
//   wr_en/wr_ch/wr_sel/wr_data : single-word write; out-of-range wr_ch is dropped
//   load_en, load_*      : whole-bank parallel load (has priority over wr_en)
//   rd_cos_1..rd_sin_2   : flattened contents, ch i at [W_W*i +: W_W]
module bf_weight_bank
  import bf_pkg::*;
#(
  parameter int unsigned NUM_CH = bf_pkg::NUM_CH,
  parameter int unsigned W_W    = bf_pkg::W_W
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [2:0]            wr_ch,
  input  logic [1:0]            wr_sel,
  input  logic [W_W-1:0]        wr_data,
  input  logic                  load_en,
  input  logic [NUM_CH*W_W-1:0] load_cos_1,
  input  logic [NUM_CH*W_W-1:0] load_sin_1,
  input  logic [NUM_CH*W_W-1:0] load_cos_2,
  input  logic [NUM_CH*W_W-1:0] load_sin_2,
  output logic [NUM_CH*W_W-1:0] rd_cos_1,
  output logic [NUM_CH*W_W-1:0] rd_sin_1,
  output logic [NUM_CH*W_W-1:0] rd_cos_2,
  output logic [NUM_CH*W_W-1:0] rd_sin_2
);

  logic [W_W-1:0] mem_q [NUM_CH][4];

  always_ff @(posedge clock) begin
    if (reset) begin
      mem_q <= '{default: '0};
    end else if (load_en) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        mem_q[i][WSEL_COS1] <= load_cos_1[W_W*i +: W_W];
        mem_q[i][WSEL_SIN1] <= load_sin_1[W_W*i +: W_W];
        mem_q[i][WSEL_COS2] <= load_cos_2[W_W*i +: W_W];
        mem_q[i][WSEL_SIN2] <= load_sin_2[W_W*i +: W_W];
      end
    end else if (wr_en && (32'(wr_ch) < NUM_CH)) begin
      mem_q[wr_ch][wr_sel] <= wr_data;
    end
  end

  always_comb begin
    rd_cos_1 = '0;
    rd_sin_1 = '0;
    rd_cos_2 = '0;
    rd_sin_2 = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      rd_cos_1[W_W*i +: W_W] = mem_q[i][WSEL_COS1];
      rd_sin_1[W_W*i +: W_W] = mem_q[i][WSEL_SIN1];
      rd_cos_2[W_W*i +: W_W] = mem_q[i][WSEL_COS2];
      rd_sin_2[W_W*i +: W_W] = mem_q[i][WSEL_SIN2];
    end
  end

endmodule

// File: rtl/bf_weight_ctrl.sv
// Beamformer phase-shift weight controller.
// Weight writes land in a shadow bank; a commit arms a transfer that copies the
// whole shadow bank into the active bank on the next tick_i, so every channel
// changes beam on the same edge at a prescale-phase boundary.
// Ports:
//   clock, reset            : system clock, synchronous active-high reset
//   tick_i                  : prescale-phase boundary pulse
//   wr_valid/wr_ready, wr_ch/wr_sel/wr_data : shadow write port
//   commit_valid/commit_ready : commit request handshake
//   commit_done_o           : pulse on the cycle after the active bank updates
//   pending_o               : commit accepted, swap not yet done
//   commit_cnt_o            : completed swap count (wraps)
//   w_cos_1_o..w_sin_2_o    : active weights, ch i at [W_W*i +: W_W]
// Optional (macro BF_WCTRL_READBACK_EN):
//   rd_valid/rd_ch/rd_sel/rd_bank -> rd_data_o/rd_data_valid_o one cycle later
module bf_weight_ctrl
  import bf_pkg::*;
#(
  parameter int unsigned NUM_CH = bf_pkg::NUM_CH,
  parameter int unsigned W_W    = bf_pkg::W_W,
  parameter int unsigned CNT_W  = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  tick_i,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [2:0]            wr_ch,
  input  logic [1:0]            wr_sel,
  input  logic [W_W-1:0]        wr_data,
  input  logic                  commit_valid,
  output logic                  commit_ready,
  output logic                  commit_done_o,
  output logic                  pending_o,
  output logic [CNT_W-1:0]      commit_cnt_o,
  output logic [NUM_CH*W_W-1:0] w_cos_1_o,
  output logic [NUM_CH*W_W-1:0] w_sin_1_o,
  output logic [NUM_CH*W_W-1:0] w_cos_2_o,
  output logic [NUM_CH*W_W-1:0] w_sin_2_o
`ifdef BF_WCTRL_READBACK_EN
  ,
  input  logic                  rd_valid,
  input  logic [2:0]            rd_ch,
  input  logic [1:0]            rd_sel,
  input  logic                  rd_bank,
  output logic [W_W-1:0]        rd_data_o,
  output logic                  rd_data_valid_o
`endif
);

  state_t state_q, state_d;
  logic   swap;
  logic   shadow_wr;

  logic [NUM_CH*W_W-1:0] sh_cos_1, sh_sin_1, sh_cos_2, sh_sin_2;

  // State register
  always_ff @(posedge clock) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state: tick_i in IDLE is ignored, so a commit accepted together
  // with a tick waits for the following tick.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (commit_valid) state_d = ARMED;
      ARMED:   if (tick_i)       state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs: handshakes open only in IDLE, which freezes the shadow bank while armed
  always_comb begin
    wr_ready     = 1'b0;
    commit_ready = 1'b0;
    pending_o    = 1'b0;
    swap         = 1'b0;
    unique case (state_q)
      IDLE: begin
        wr_ready     = 1'b1;
        commit_ready = 1'b1;
      end
      ARMED: begin
        pending_o = 1'b1;
        swap      = tick_i;
      end
      default: ;
    endcase
  end

  assign shadow_wr = wr_valid & wr_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      commit_done_o <= 1'b0;
      commit_cnt_o  <= '0;
    end else begin
      commit_done_o <= swap;
      if (swap) commit_cnt_o <= commit_cnt_o + 1'b1;
    end
  end

  bf_weight_bank #(.NUM_CH(NUM_CH), .W_W(W_W)) u_shadow (
    .clock      (clock),
    .reset      (reset),
    .wr_en      (shadow_wr),
    .wr_ch      (wr_ch),
    .wr_sel     (wr_sel),
    .wr_data    (wr_data),
    .load_en    (1'b0),
    .load_cos_1 ('0),
    .load_sin_1 ('0),
    .load_cos_2 ('0),
    .load_sin_2 ('0),
    .rd_cos_1   (sh_cos_1),
    .rd_sin_1   (sh_sin_1),
    .rd_cos_2   (sh_cos_2),
    .rd_sin_2   (sh_sin_2)
  );

  bf_weight_bank #(.NUM_CH(NUM_CH), .W_W(W_W)) u_active (
    .clock      (clock),
    .reset      (reset),
    .wr_en      (1'b0),
    .wr_ch      ('0),
    .wr_sel     ('0),
    .wr_data    ('0),
    .load_en    (swap),
    .load_cos_1 (sh_cos_1),
    .load_sin_1 (sh_sin_1),
    .load_cos_2 (sh_cos_2),
    .load_sin_2 (sh_sin_2),
    .rd_cos_1   (w_cos_1_o),
    .rd_sin_1   (w_sin_1_o),
    .rd_cos_2   (w_cos_2_o),
    .rd_sin_2   (w_sin_2_o)
  );

`ifdef BF_WCTRL_READBACK_EN
  logic [NUM_CH*W_W-1:0] rd_bus;
  logic [W_W-1:0]        rd_word;

  // Reads sample the banks' current contents, i.e. before any same-edge write or swap
  always_comb begin
    rd_bus  = '0;
    rd_word = '0;
    unique case (rd_sel)
      WSEL_COS1: rd_bus = rd_bank ? w_cos_1_o : sh_cos_1;
      WSEL_SIN1: rd_bus = rd_bank ? w_sin_1_o : sh_sin_1;
      WSEL_COS2: rd_bus = rd_bank ? w_cos_2_o : sh_cos_2;
      WSEL_SIN2: rd_bus = rd_bank ? w_sin_2_o : sh_sin_2;
      default:   rd_bus = '0;
    endcase
    if (32'(rd_ch) < NUM_CH) rd_word = rd_bus[W_W*rd_ch +: W_W];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_data_valid_o <= 1'b0;
      rd_data_o       <= '0;
    end else begin
      rd_data_valid_o <= rd_valid;
      if (rd_valid) rd_data_o <= rd_word;
    end
  end
`endif

endmodule

// File: tb/tb_bf_weight_ctrl.sv
// Self-checking bench for bf_weight_ctrl: directed scenarios plus randomized
// traffic, all checked against a behavioural model of the shadow/active banks.
module tb_bf_weight_ctrl;

  localparam int NCH = 8;
  localparam int WW  = 5;

  logic            clock = 1'b0;
  logic            reset;
  logic            tick_i;
  logic            wr_valid;
  logic            wr_ready;
  logic [2:0]      wr_ch;
  logic [1:0]      wr_sel;
  logic [WW-1:0]   wr_data;
  logic            commit_valid;
  logic            commit_ready;
  logic            commit_done_o;
  logic            pending_o;
  logic [7:0]      commit_cnt_o;
  logic [NCH*WW-1:0] w_cos_1_o, w_sin_1_o, w_cos_2_o, w_sin_2_o;
`ifdef BF_WCTRL_READBACK_EN
  logic            rd_valid;
  logic [2:0]      rd_ch;
  logic [1:0]      rd_sel;
  logic            rd_bank;
  logic [WW-1:0]   rd_data_o;
  logic            rd_data_valid_o;
  bit              rd_rand = 1'b1;
  logic [WW-1:0]   m_rd_data;
  bit              m_rd_valid;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model
  logic [WW-1:0] m_sh  [NCH][4];
  logic [WW-1:0] m_act [NCH][4];
  bit            m_pend;
  bit            m_done;
  logic [7:0]    m_cnt;

  always #5 clock = ~clock;

  bf_weight_ctrl #(.NUM_CH(NCH), .W_W(WW), .CNT_W(8)) dut (
    .clock         (clock),
    .reset         (reset),
    .tick_i        (tick_i),
    .wr_valid      (wr_valid),
    .wr_ready      (wr_ready),
    .wr_ch         (wr_ch),
    .wr_sel        (wr_sel),
    .wr_data       (wr_data),
    .commit_valid  (commit_valid),
    .commit_ready  (commit_ready),
    .commit_done_o (commit_done_o),
    .pending_o     (pending_o),
    .commit_cnt_o  (commit_cnt_o),
    .w_cos_1_o     (w_cos_1_o),
    .w_sin_1_o     (w_sin_1_o),
    .w_cos_2_o     (w_cos_2_o),
    .w_sin_2_o     (w_sin_2_o)
`ifdef BF_WCTRL_READBACK_EN
    ,
    .rd_valid        (rd_valid),
    .rd_ch           (rd_ch),
    .rd_sel          (rd_sel),
    .rd_bank         (rd_bank),
    .rd_data_o       (rd_data_o),
    .rd_data_valid_o (rd_data_valid_o)
`endif
  );

  task automatic model_clear();
    for (int c = 0; c < NCH; c++)
      for (int s = 0; s < 4; s++) begin
        m_sh[c][s]  = '0;
        m_act[c][s] = '0;
      end
    m_pend = 0;
    m_done = 0;
    m_cnt  = '0;
`ifdef BF_WCTRL_READBACK_EN
    m_rd_valid = 0;
    m_rd_data  = '0;
`endif
  endtask

  // One clock cycle starting at a negedge: drive, check handshakes, advance
  // the model at the posedge, then check registered outputs at the next negedge.
  task automatic step(input logic wv, input logic [2:0] ch, input logic [1:0] sel,
                      input logic [WW-1:0] d, input logic cv, input logic tk);
    logic [NCH*WW-1:0] e_c1, e_s1, e_c2, e_s2;
    bit done_n;
    wr_valid = wv; wr_ch = ch; wr_sel = sel; wr_data = d;
    commit_valid = cv; tick_i = tk;
`ifdef BF_WCTRL_READBACK_EN
    if (rd_rand) begin
      rd_valid = 1'($urandom_range(0, 1));
      rd_ch    = 3'($urandom_range(0, 7));
      rd_sel   = 2'($urandom_range(0, 3));
      rd_bank  = 1'($urandom_range(0, 1));
    end
`endif
    #1;
    checks++;
    if (wr_ready !== logic'(!m_pend)) begin
      errors++; $display("FAIL wr_ready got %0b want %0b", wr_ready, !m_pend);
    end
    checks++;
    if (commit_ready !== logic'(!m_pend)) begin
      errors++; $display("FAIL commit_ready got %0b want %0b", commit_ready, !m_pend);
    end
    checks++;
    if (pending_o !== logic'(m_pend)) begin
      errors++; $display("FAIL pending_o got %0b want %0b", pending_o, m_pend);
    end
`ifdef BF_WCTRL_READBACK_EN
    m_rd_valid = rd_valid;
    if (rd_valid) m_rd_data = (rd_ch < NCH) ? (rd_bank ? m_act[rd_ch][rd_sel] : m_sh[rd_ch][rd_sel]) : '0;
`endif
    @(posedge clock);
    done_n = 0;
    if (!m_pend) begin
      if (wv && ch < NCH) m_sh[ch][sel] = d;
      if (cv) m_pend = 1;
    end else if (tk) begin
      m_act  = m_sh;
      m_cnt  = m_cnt + 8'd1;
      m_pend = 0;
      done_n = 1;
    end
    m_done = done_n;
    @(negedge clock);
    for (int c = 0; c < NCH; c++) begin
      e_c1[WW*c +: WW] = m_act[c][0];
      e_s1[WW*c +: WW] = m_act[c][1];
      e_c2[WW*c +: WW] = m_act[c][2];
      e_s2[WW*c +: WW] = m_act[c][3];
    end
    checks++;
    if (w_cos_1_o !== e_c1) begin errors++; $display("FAIL w_cos_1_o got %h want %h", w_cos_1_o, e_c1); end
    checks++;
    if (w_sin_1_o !== e_s1) begin errors++; $display("FAIL w_sin_1_o got %h want %h", w_sin_1_o, e_s1); end
    checks++;
    if (w_cos_2_o !== e_c2) begin errors++; $display("FAIL w_cos_2_o got %h want %h", w_cos_2_o, e_c2); end
    checks++;
    if (w_sin_2_o !== e_s2) begin errors++; $display("FAIL w_sin_2_o got %h want %h", w_sin_2_o, e_s2); end
    checks++;
    if (commit_done_o !== logic'(m_done)) begin
      errors++; $display("FAIL commit_done_o got %0b want %0b", commit_done_o, m_done);
    end
    checks++;
    if (commit_cnt_o !== m_cnt) begin
      errors++; $display("FAIL commit_cnt_o got %0d want %0d", commit_cnt_o, m_cnt);
    end
`ifdef BF_WCTRL_READBACK_EN
    checks++;
    if (rd_data_valid_o !== logic'(m_rd_valid)) begin
      errors++; $display("FAIL rd_data_valid_o got %0b want %0b", rd_data_valid_o, m_rd_valid);
    end
    if (m_rd_valid) begin
      checks++;
      if (rd_data_o !== m_rd_data) begin
        errors++; $display("FAIL rd_data_o got %h want %h", rd_data_o, m_rd_data);
      end
    end
`endif
  endtask

  task automatic idle(input int n, input logic tk);
    for (int i = 0; i < n; i++) step(1'b0, 3'd0, 2'd0, '0, 1'b0, tk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    wr_valid = 0; commit_valid = 0; tick_i = 0; wr_ch = '0; wr_sel = '0; wr_data = '0;
`ifdef BF_WCTRL_READBACK_EN
    rd_valid = 0; rd_ch = '0; rd_sel = '0; rd_bank = 0;
`endif
    repeat (2) @(posedge clock);
    model_clear();
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({w_cos_1_o, w_sin_1_o, w_cos_2_o, w_sin_2_o} !== '0) begin
      errors++; $display("FAIL reset_weights got %h want 0", {w_cos_1_o, w_sin_1_o, w_cos_2_o, w_sin_2_o});
    end
    checks++;
    if (wr_ready !== 1'b1) begin errors++; $display("FAIL reset_wr_ready got %0b want 1", wr_ready); end
    checks++;
    if (commit_cnt_o !== 8'd0) begin errors++; $display("FAIL reset_cnt got %0d want 0", commit_cnt_o); end
    checks++;
    if (pending_o !== 1'b0 || commit_done_o !== 1'b0) begin
      errors++; $display("FAIL reset_flags got %0b%0b want 00", pending_o, commit_done_o);
    end
`ifdef BF_WCTRL_READBACK_EN
    checks++;
    if (rd_data_valid_o !== 1'b0) begin errors++; $display("FAIL reset_rd_valid got %0b want 0", rd_data_valid_o); end
`endif
    idle(4, 1'b0);
  endtask

  task automatic test_basic_commit();
    step(1'b1, 3'd3, 2'd0, 5'h0B, 1'b0, 1'b0);
    step(1'b1, 3'd7, 2'd3, 5'h1F, 1'b0, 1'b0);
    step(1'b0, 3'd0, 2'd0, '0, 1'b1, 1'b0);
    idle(2, 1'b0);
    step(1'b0, 3'd0, 2'd0, '0, 1'b0, 1'b1);
    checks++;
    if (w_cos_1_o[19:15] !== 5'h0B) begin errors++; $display("FAIL basic_ch3_cos1 got %h want 0b", w_cos_1_o[19:15]); end
    checks++;
    if (w_sin_2_o[39:35] !== 5'h1F) begin errors++; $display("FAIL basic_ch7_sin2 got %h want 1f", w_sin_2_o[39:35]); end
    checks++;
    if (commit_done_o !== 1'b1 || commit_cnt_o !== 8'd1) begin
      errors++; $display("FAIL basic_done_cnt got %0b/%0d want 1/1", commit_done_o, commit_cnt_o);
    end
    idle(1, 1'b0);
  endtask

`ifdef BF_WCTRL_READBACK_EN
  task automatic test_readback();
    rd_rand = 0;
    rd_valid = 1; rd_ch = 3'd3; rd_sel = 2'd0; rd_bank = 1;
    idle(1, 1'b0);
    checks++;
    if (rd_data_o !== 5'h0B || rd_data_valid_o !== 1'b1) begin
      errors++; $display("FAIL readback_active_ch3 got %h/%0b want 0b/1", rd_data_o, rd_data_valid_o);
    end
    rd_valid = 0;
    idle(1, 1'b0);
    rd_rand = 1;
  endtask
`endif

  task automatic test_tick_same_cycle();
    step(1'b1, 3'd1, 2'd1, 5'h15, 1'b1, 1'b1);
    idle(7, 1'b0);
    checks++;
    if (pending_o !== 1'b1 || commit_done_o !== 1'b0) begin
      errors++; $display("FAIL same_tick_no_swap got pend=%0b done=%0b want 1/0", pending_o, commit_done_o);
    end
    step(1'b0, 3'd0, 2'd0, '0, 1'b0, 1'b1);
    checks++;
    if (w_sin_1_o[9:5] !== 5'h15) begin errors++; $display("FAIL same_tick_swap got %h want 15", w_sin_1_o[9:5]); end
  endtask

  task automatic test_write_while_armed();
    do_reset();
    step(1'b0, 3'd0, 2'd0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 3'd0, 2'd2, 5'h03, 1'b0, 1'b0);
    step(1'b1, 3'd0, 2'd2, 5'h03, 1'b0, 1'b1);
    checks++;
    if (w_cos_2_o[4:0] !== 5'h00) begin errors++; $display("FAIL armed_write_leaked got %h want 00", w_cos_2_o[4:0]); end
    step(1'b1, 3'd0, 2'd2, 5'h03, 1'b0, 1'b0);
    step(1'b0, 3'd0, 2'd0, '0, 1'b1, 1'b0);
    step(1'b0, 3'd0, 2'd0, '0, 1'b0, 1'b1);
    checks++;
    if (w_cos_2_o[4:0] !== 5'h03) begin errors++; $display("FAIL armed_write_second_commit got %h want 03", w_cos_2_o[4:0]); end
  endtask

  task automatic test_reset_armed();
    step(1'b1, 3'd5, 2'd1, 5'h0E, 1'b1, 1'b0);
    idle(2, 1'b0);
    do_reset();
    step(1'b0, 3'd0, 2'd0, '0, 1'b0, 1'b1);
    idle(2, 1'b0);
    checks++;
    if (commit_done_o !== 1'b0 || commit_cnt_o !== 8'd0 || w_sin_1_o !== '0) begin
      errors++; $display("FAIL reset_armed got done=%0b cnt=%0d sin1=%h want 0/0/0", commit_done_o, commit_cnt_o, w_sin_1_o);
    end
  endtask

  task automatic test_random();
    int p = 0;
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
           5'($urandom), 1'($urandom_range(0, 5) == 0), 1'(p == 7));
      p = (p + 1) % 8;
    end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 256; i++) begin
      step(1'b1, 3'(i % 8), 2'(i % 4), 5'(i), 1'b1, 1'b0);
      step(1'b0, 3'd0, 2'd0, '0, 1'b0, 1'b1);
    end
    checks++;
    if (commit_cnt_o !== 8'd0) begin errors++; $display("FAIL cnt_wrap got %0d want 0", commit_cnt_o); end
  endtask

  initial begin
    reset = 1'b1;
    wr_valid = 0; commit_valid = 0; tick_i = 0; wr_ch = '0; wr_sel = '0; wr_data = '0;
`ifdef BF_WCTRL_READBACK_EN
    rd_valid = 0; rd_ch = '0; rd_sel = '0; rd_bank = 0;
`endif
    model_clear();
    @(negedge clock);
    test_reset();
    test_basic_commit();
`ifdef BF_WCTRL_READBACK_EN
    test_readback();
`endif
    test_tick_same_cycle();
    test_write_while_armed();
    test_reset_armed();
    test_random();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
